// File: rtl/m_axil_cmd.sv
// Single-outstanding AXI-lite master: turns one command-port request into an
// AXI-lite read or write and returns the result on the response port.
module m_axil_cmd #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 40,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  axi_clock,
  input  logic                  rst,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  // AXI-lite master
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic [15:0]           err_count
);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_resp;
  logic [15:0]           r_errCount;
  logic                  w_accept;
  logic                  w_awDone;
  logic                  w_wDone;
  logic                  w_enterRsp;
  logic [1:0]            w_newResp;

  assign cmd_ready = (r_state == IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;
  // A channel counts as done if it already handshook or is handshaking now
  assign w_awDone  = !r_awvalid || m_axil_awready;
  assign w_wDone   = !r_wvalid || m_axil_wready;

  assign m_axil_awaddr  = r_addr;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = r_awvalid;
  assign m_axil_wdata   = r_wdata;
  assign m_axil_wstrb   = r_wstrb;
  assign m_axil_wvalid  = r_wvalid;
  assign m_axil_bready  = (r_state == WR_B) && !rst;
  assign m_axil_araddr  = r_addr;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = (r_state == RD_AR) && !rst;
  assign m_axil_rready  = (r_state == RD_R) && !rst;

  assign rsp_valid = (r_state == RSP) && !rst;
  assign rsp_write = r_write;
  assign rsp_rdata = r_rdata;
  assign rsp_resp  = r_resp;
  assign err_count = r_errCount;

  always_ff @(posedge axi_clock) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_enterRsp  = 1'b0;
    w_newResp   = 2'b00;
    case (r_state)
      IDLE:  if (w_accept) w_nextState = cmd_write ? WR : RD_AR;
      WR:    if (w_awDone && w_wDone) w_nextState = WR_B;
      WR_B:  if (m_axil_bvalid) begin
               w_nextState = RSP;
               w_enterRsp  = 1'b1;
               w_newResp   = m_axil_bresp;
             end
      RD_AR: if (m_axil_arready) w_nextState = RD_R;
      RD_R:  if (m_axil_rvalid) begin
               w_nextState = RSP;
               w_enterRsp  = 1'b1;
               w_newResp   = m_axil_rresp;
             end
      RSP:   if (rsp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Command capture, per-channel valid retirement and response capture
  always_ff @(posedge axi_clock) begin
    if (rst) begin
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_rdata    <= '0;
      r_resp     <= 2'b00;
      r_errCount <= 16'd0;
    end else begin
      if (w_accept) begin
        r_write   <= cmd_write;
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_wstrb   <= cmd_wstrb;
        r_awvalid <= cmd_write;
        r_wvalid  <= cmd_write;
      end
      if (r_state == WR) begin
        if (r_awvalid && m_axil_awready) r_awvalid <= 1'b0;
        if (r_wvalid && m_axil_wready)   r_wvalid  <= 1'b0;
      end
      if (r_state == RD_R && m_axil_rvalid) r_rdata <= m_axil_rdata;
      else if (r_state == WR_B && m_axil_bvalid) r_rdata <= '0;
      if (w_enterRsp) begin
        r_resp <= w_newResp;
        if (w_newResp != 2'b00 && r_errCount != 16'hFFFF)
          r_errCount <= r_errCount + 16'd1;
      end
    end
  end

endmodule
